// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// The in-order pipeline writeback always wins the single write port. A result
// from the long-latency unit waits in a one-entry buffer and is written on the
// next cycle the pipeline leaves the port free. A per-register busy scoreboard
// marks registers with an outstanding long-unit write so decode can detect
// hazards.
//
// state | meaning
// EMPTY | no long-unit result buffered, l_ready=1
// HELD  | one result buffered, waiting for a free write slot
module regfile_wb_arbiter #(
    parameter int REG_W      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int REG_NUM    = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_we,
    input  logic [REG_ADDR_W-1:0] p_waddr,
    input  logic [REG_W-1:0]      p_wdata,
    input  logic                  l_valid,
    input  logic [REG_ADDR_W-1:0] l_waddr,
    input  logic [REG_W-1:0]      l_wdata,
    output logic                  l_ready,
    input  logic                  iss_set,
    input  logic [REG_ADDR_W-1:0] iss_addr,
    input  logic [REG_ADDR_W-1:0] q_addr1,
    input  logic [REG_ADDR_W-1:0] q_addr2,
    output logic                  q_busy1,
    output logic                  q_busy2,
    output logic                  stall_req,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [REG_W-1:0]      wdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } buf_state_t;

    buf_state_t            state;
    buf_state_t            state_next;
    logic [REG_ADDR_W-1:0] hold_addr;
    logic [REG_W-1:0]      hold_data;
    logic [CNT_W-1:0]      wait_cnt;
    logic [REG_NUM-1:0]    busy;
    logic [REG_NUM-1:0]    busy_next;

    logic hold_valid;
    logic p_real;
    logic accept;
    logic drain;
    logic drain_clr;
    logic iss_real;

    assign hold_valid = (state == HELD);
    assign p_real     = p_we && (p_waddr != '0);
    assign accept     = l_valid && !hold_valid;
    assign drain      = hold_valid && !p_real;
    // A drained r0 result frees the buffer but never reaches the regfile.
    assign drain_clr  = drain && (hold_addr != '0);
    assign iss_real   = iss_set && (iss_addr != '0);

    // Both come from registered state only, so the controller sees no p_*/l_* loop.
    assign l_ready    = !hold_valid;
    assign stall_req  = hold_valid && (wait_cnt >= CNT_W'(STARVE_MAX));

    // Buffer state register.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // Next buffer state and the write-port mux; reset forces the port idle.
    always_comb begin
        state_next = state;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        case (state)
            EMPTY:   if (accept) state_next = HELD;
            HELD:    if (drain)  state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
        if (!rst) begin
            if (p_real) begin
                we    = 1'b1;
                waddr = p_waddr;
                wdata = p_wdata;
            end else if (drain_clr) begin
                we    = 1'b1;
                waddr = hold_addr;
                wdata = hold_data;
            end
        end
    end

    // Held entry payload and starvation counter (saturating).
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr <= '0;
            hold_data <= '0;
            wait_cnt  <= '0;
        end else if (accept) begin
            hold_addr <= l_waddr;
            hold_data <= l_wdata;
            wait_cnt  <= '0;
        end else if (hold_valid && p_real && (wait_cnt < CNT_W'(STARVE_MAX))) begin
            wait_cnt  <= wait_cnt + CNT_W'(1);
        end
    end

    // Scoreboard update: clear on drain, then set on issue so set wins.
    always_comb begin
        busy_next = busy;
        if (drain_clr) busy_next[hold_addr] = 1'b0;
        if (iss_real)  busy_next[iss_addr]  = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

    // Hazard queries with same-cycle bypass of the issue set and drain clear.
    always_comb begin
        if (q_addr1 == '0)                           q_busy1 = 1'b0;
        else if (iss_real && (iss_addr == q_addr1))  q_busy1 = 1'b1;
        else if (drain_clr && (hold_addr == q_addr1)) q_busy1 = 1'b0;
        else                                         q_busy1 = busy[q_addr1];

        if (q_addr2 == '0)                           q_busy2 = 1'b0;
        else if (iss_real && (iss_addr == q_addr2))  q_busy2 = 1'b1;
        else if (drain_clr && (hold_addr == q_addr2)) q_busy2 = 1'b0;
        else                                         q_busy2 = busy[q_addr2];
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by a randomized
// run against a behavioural model of the buffer, scoreboard and write port.
module tb_regfile_wb_arbiter;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;
    localparam int STARVE_MAX = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  p_we;
    logic [REG_ADDR_W-1:0] p_waddr;
    logic [REG_W-1:0]      p_wdata;
    logic                  l_valid;
    logic [REG_ADDR_W-1:0] l_waddr;
    logic [REG_W-1:0]      l_wdata;
    logic                  l_ready;
    logic                  iss_set;
    logic [REG_ADDR_W-1:0] iss_addr;
    logic [REG_ADDR_W-1:0] q_addr1;
    logic [REG_ADDR_W-1:0] q_addr2;
    logic                  q_busy1;
    logic                  q_busy2;
    logic                  stall_req;
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_W-1:0]      wdata;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit              m_held;
    int              m_addr;
    logic [REG_W-1:0] m_data;
    int              m_wait;
    int              m_age;
    bit              m_busy [REG_NUM];

    // Model expectations for the current cycle
    logic                  e_we;
    logic [REG_ADDR_W-1:0] e_waddr;
    logic [REG_W-1:0]      e_wdata;
    logic                  e_lready;
    logic                  e_stall;
    logic                  e_qb1;
    logic                  e_qb2;
    bit                    e_drain;

    regfile_wb_arbiter #(
        .REG_W(REG_W), .REG_ADDR_W(REG_ADDR_W), .REG_NUM(REG_NUM), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
        .l_valid(l_valid), .l_waddr(l_waddr), .l_wdata(l_wdata), .l_ready(l_ready),
        .iss_set(iss_set), .iss_addr(iss_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .stall_req(stall_req), .we(we), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic q_model(int a, bit drain, bit iss_real);
        if (a == 0) return 1'b0;
        if (iss_real && int'(iss_addr) == a) return 1'b1;
        if (drain && m_addr != 0 && m_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_eval();
        bit p_real;
        bit iss_real;
        p_real   = p_we && (p_waddr != 0);
        iss_real = iss_set && (iss_addr != 0);
        e_drain  = m_held && !p_real;
        e_we = 1'b0; e_waddr = '0; e_wdata = '0;
        if (!rst) begin
            if (p_real) begin
                e_we = 1'b1; e_waddr = p_waddr; e_wdata = p_wdata;
            end else if (e_drain && m_addr != 0) begin
                e_we = 1'b1; e_waddr = REG_ADDR_W'(m_addr); e_wdata = m_data;
            end
        end
        e_lready = !m_held;
        e_stall  = m_held && (m_wait >= STARVE_MAX);
        e_qb1    = q_model(int'(q_addr1), e_drain, iss_real);
        e_qb2    = q_model(int'(q_addr2), e_drain, iss_real);
    endtask

    task automatic model_step();
        model_eval();
        if (rst) begin
            m_held = 0; m_wait = 0; m_age = 0; m_addr = 0; m_data = '0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            if (e_drain && m_addr != 0) m_busy[m_addr] = 0;
            if (iss_set && iss_addr != 0) m_busy[iss_addr] = 1;
            if (l_valid && !m_held) begin
                m_held = 1; m_addr = int'(l_waddr); m_data = l_wdata; m_wait = 0; m_age = 0;
            end else if (e_drain) begin
                m_held = 0;
            end else if (m_held) begin
                if (m_wait < STARVE_MAX) m_wait++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; p_we = 0; p_waddr = '0; p_wdata = '0;
        l_valid = 0; l_waddr = '0; l_wdata = '0;
        iss_set = 0; iss_addr = '0; q_addr1 = '0; q_addr2 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; p_we = 1; p_waddr = 5'd3; p_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we); end
        n_cmp++; if (waddr !== '0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
        n_cmp++; if (wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata); end
        tick();
        tick();
        idle_inputs(); q_addr1 = 5'd5; q_addr2 = 5'd31;
        #1;
        n_cmp++; if (l_ready !== 1'b1) begin n_fail++; $display("FAIL reset_l_ready: got %b want 1", l_ready); end
        n_cmp++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        n_cmp++; if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_q_busy: got %b%b want 00", q_busy1, q_busy2); end
        tick();
    endtask

    task automatic test_pipe_write();
        idle_inputs(); p_we = 1; p_waddr = 5'd3; p_wdata = 32'h11;
        #1;
        n_cmp++; if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h11) begin
            n_fail++; $display("FAIL pipe_write: got we=%b a=%0d d=%h want we=1 a=3 d=11", we, waddr, wdata); end
        n_cmp++; if (l_ready !== 1'b1) begin n_fail++; $display("FAIL pipe_l_ready: got %b want 1", l_ready); end
        tick();
        idle_inputs(); p_we = 1; p_waddr = 5'd0; p_wdata = 32'h77;
        #1;
        n_cmp++; if (we !== 1'b0) begin n_fail++; $display("FAIL pipe_r0_we: got %b want 0", we); end
        tick();
    endtask

    task automatic test_long_result();
        idle_inputs(); iss_set = 1; iss_addr = 5'd5; q_addr1 = 5'd5;
        #1;
        n_cmp++; if (q_busy1 !== 1'b1) begin n_fail++; $display("FAIL long_busy_iss: got %b want 1", q_busy1); end
        tick();
        idle_inputs(); q_addr1 = 5'd5;
        #1;
        n_cmp++; if (q_busy1 !== 1'b1) begin n_fail++; $display("FAIL long_busy_wait: got %b want 1", q_busy1); end
        tick();
        idle_inputs(); q_addr1 = 5'd5; l_valid = 1; l_waddr = 5'd5; l_wdata = 32'hAB;
        #1;
        n_cmp++; if (q_busy1 !== 1'b1 || we !== 1'b0 || l_ready !== 1'b1) begin
            n_fail++; $display("FAIL long_accept: got busy=%b we=%b rdy=%b want 1 0 1", q_busy1, we, l_ready); end
        tick();
        idle_inputs(); q_addr1 = 5'd5;
        #1;
        n_cmp++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hAB) begin
            n_fail++; $display("FAIL long_drain: got we=%b a=%0d d=%h want we=1 a=5 d=ab", we, waddr, wdata); end
        n_cmp++; if (q_busy1 !== 1'b0 || l_ready !== 1'b0) begin
            n_fail++; $display("FAIL long_drain_state: got busy=%b rdy=%b want 0 0", q_busy1, l_ready); end
        tick();
        #1;
        n_cmp++; if (q_busy1 !== 1'b0 || l_ready !== 1'b1 || we !== 1'b0) begin
            n_fail++; $display("FAIL long_after: got busy=%b rdy=%b we=%b want 0 1 0", q_busy1, l_ready, we); end
        tick();
    endtask

    task automatic test_starve();
        idle_inputs(); l_valid = 1; l_waddr = 5'd7; l_wdata = 32'hCD;
        p_we = 1; p_waddr = 5'd1; p_wdata = $urandom;
        #1;
        n_cmp++; if (we !== 1'b1 || waddr !== 5'd1) begin
            n_fail++; $display("FAIL starve_accept_pipe: got we=%b a=%0d want 1 1", we, waddr); end
        tick();
        for (int i = 1; i <= STARVE_MAX + 1; i++) begin
            idle_inputs(); p_we = 1; p_waddr = 5'd1; p_wdata = $urandom;
            #1;
            n_cmp++; if (we !== 1'b1 || waddr !== 5'd1 || wdata !== p_wdata) begin
                n_fail++; $display("FAIL starve_pipe_%0d: got we=%b a=%0d want 1 1", i, we, waddr); end
            n_cmp++; if (stall_req !== (i > STARVE_MAX)) begin
                n_fail++; $display("FAIL starve_stall_%0d: got %b want %b", i, stall_req, i > STARVE_MAX); end
            tick();
        end
        idle_inputs();
        #1;
        n_cmp++; if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'hCD || stall_req !== 1'b1) begin
            n_fail++; $display("FAIL starve_drain: got we=%b a=%0d d=%h st=%b want 1 7 cd 1", we, waddr, wdata, stall_req); end
        tick();
        #1;
        n_cmp++; if (stall_req !== 1'b0 || l_ready !== 1'b1) begin
            n_fail++; $display("FAIL starve_after: got st=%b rdy=%b want 0 1", stall_req, l_ready); end
        tick();
    endtask

    task automatic test_set_clear_same();
        idle_inputs(); iss_set = 1; iss_addr = 5'd9;
        tick();
        idle_inputs(); l_valid = 1; l_waddr = 5'd9; l_wdata = 32'h99;
        tick();
        idle_inputs(); iss_set = 1; iss_addr = 5'd9; q_addr1 = 5'd9;
        #1;
        n_cmp++; if (we !== 1'b1 || waddr !== 5'd9) begin
            n_fail++; $display("FAIL setclr_drain: got we=%b a=%0d want 1 9", we, waddr); end
        n_cmp++; if (q_busy1 !== 1'b1) begin n_fail++; $display("FAIL setclr_bypass: got %b want 1", q_busy1); end
        tick();
        idle_inputs(); q_addr1 = 5'd9;
        #1;
        n_cmp++; if (q_busy1 !== 1'b1) begin n_fail++; $display("FAIL setclr_after: got %b want 1", q_busy1); end
        tick();
    endtask

    task automatic test_reset_held();
        idle_inputs(); l_valid = 1; l_waddr = 5'd12; l_wdata = 32'h1234; iss_set = 1; iss_addr = 5'd12;
        tick();
        idle_inputs(); rst = 1;
        #1;
        n_cmp++; if (we !== 1'b0) begin n_fail++; $display("FAIL rsthold_we: got %b want 0", we); end
        tick();
        idle_inputs(); q_addr1 = 5'd12; q_addr2 = 5'd9;
        #1;
        n_cmp++; if (we !== 1'b0 || l_ready !== 1'b1) begin
            n_fail++; $display("FAIL rsthold_after: got we=%b rdy=%b want 0 1", we, l_ready); end
        n_cmp++; if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin
            n_fail++; $display("FAIL rsthold_busy: got %b%b want 00", q_busy1, q_busy2); end
        tick();
    endtask

    task automatic test_zero_addr();
        idle_inputs(); iss_set = 1; iss_addr = 5'd0; l_valid = 1; l_waddr = 5'd0; l_wdata = 32'h55;
        q_addr1 = 5'd0;
        #1;
        n_cmp++; if (q_busy1 !== 1'b0) begin n_fail++; $display("FAIL zero_busy_iss: got %b want 0", q_busy1); end
        tick();
        idle_inputs(); q_addr1 = 5'd0;
        #1;
        n_cmp++; if (we !== 1'b0 || l_ready !== 1'b0 || q_busy1 !== 1'b0) begin
            n_fail++; $display("FAIL zero_drain: got we=%b rdy=%b busy=%b want 0 0 0", we, l_ready, q_busy1); end
        tick();
        #1;
        n_cmp++; if (l_ready !== 1'b1 || we !== 1'b0) begin
            n_fail++; $display("FAIL zero_free: got rdy=%b we=%b want 1 0", l_ready, we); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            // Controller obeys stall_req immediately (driven from the model).
            p_we     = (m_held && m_wait >= STARVE_MAX) ? 1'b0 : ($urandom_range(0, 3) != 0);
            p_waddr  = REG_ADDR_W'($urandom_range(0, REG_NUM - 1));
            p_wdata  = $urandom;
            l_valid  = ($urandom_range(0, 2) == 0);
            l_waddr  = REG_ADDR_W'($urandom_range(0, REG_NUM - 1));
            l_wdata  = $urandom;
            iss_set  = ($urandom_range(0, 3) == 0);
            iss_addr = REG_ADDR_W'($urandom_range(0, REG_NUM - 1));
            q_addr1  = (c % 2 == 0) ? REG_ADDR_W'(m_addr) : REG_ADDR_W'($urandom_range(0, REG_NUM - 1));
            q_addr2  = REG_ADDR_W'($urandom_range(0, REG_NUM - 1));
            model_eval();
            #1;
            n_cmp++; if (we !== e_we || waddr !== e_waddr || wdata !== e_wdata) begin
                n_fail++; $display("FAIL rand_port c=%0d: got %b/%0d/%h want %b/%0d/%h",
                                   c, we, waddr, wdata, e_we, e_waddr, e_wdata); end
            n_cmp++; if (l_ready !== e_lready || stall_req !== e_stall) begin
                n_fail++; $display("FAIL rand_ctl c=%0d: got rdy=%b st=%b want rdy=%b st=%b",
                                   c, l_ready, stall_req, e_lready, e_stall); end
            n_cmp++; if (q_busy1 !== e_qb1 || q_busy2 !== e_qb2) begin
                n_fail++; $display("FAIL rand_busy c=%0d: got %b%b want %b%b", c, q_busy1, q_busy2, e_qb1, e_qb2); end
            if (m_held) begin
                m_age++;
                if (e_drain) begin
                    n_cmp++; if (m_age > STARVE_MAX + 2) begin
                        n_fail++; $display("FAIL rand_wait c=%0d: got %0d cycles want <= %0d", c, m_age, STARVE_MAX + 2); end
                end
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        m_held = 0; m_wait = 0; m_age = 0; m_addr = 0; m_data = '0;
        foreach (m_busy[i]) m_busy[i] = 0;
        @(negedge clk);
        test_reset();
        test_pipe_write();
        test_long_result();
        test_starve();
        test_set_clear_same();
        test_reset_held();
        test_zero_addr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
